pcie_ats_req_arb: RTL and testbench
===================================

PCIE_ATS_REQ_ARB -- requirements
Module: pcie_ats_req_arb

Interface
REQ-001 The block SHALL have parameter NUM_PFS, default 8, the number of PF requesters; legal range 1..8.
REQ-002 The block SHALL have parameter ATS_CAP_EN, default all-ones NUM_PFS-bit vector, the per-PF ATS capability enable.
REQ-003 The block SHALL have parameter NUM_TAGS, default 16, the maximum number of outstanding translations; power of two, 2..32.
REQ-004 Port clk, input, 1: the single clock.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Port req_valid, input, NUM_PFS: per-PF translation request valid.
REQ-007 Port req_addr, input, NUM_PFS x 64: per-PF untranslated address; bits [11:0] ignored.
REQ-008 Port req_ready, output, NUM_PFS: per-PF request accept, one-hot or zero.
REQ-009 Port tx_valid, input/output pair: tx_valid output 1, tx_ready input 1, the translation-request egress handshake.
REQ-010 Port tx_pf, output, 3 / tx_addr, output, 52 / tx_tag, output, $clog2(NUM_TAGS): egress payload (tx_addr = req_addr[63:12]).
REQ-011 Port cpl_valid, input, 1 / cpl_tag, input, $clog2(NUM_TAGS): translation completion returning a tag.
REQ-012 Port err_no_cap, output, 1 / err_pf, output, 3: one-cycle pulse flagging a request from a PF with ATS disabled.
REQ-013 Port err_bad_cpl, output, 1: one-cycle pulse flagging a completion carrying a tag that is not outstanding.
REQ-014 Port outstanding, output, $clog2(NUM_TAGS)+1: count of allocated tags.

Function
REQ-015 The FSM SHALL have states IDLE and HOLD.
REQ-016 In IDLE, if any req_valid is set and a free tag exists, the round-robin winner SHALL be granted: req_ready for that PF high for exactly one cycle, and the FSM SHALL go to HOLD.
REQ-017 Round-robin priority SHALL start at PF0 after reset and SHALL rotate to the PF after the last granted PF.
REQ-018 A granted PF whose ATS_CAP_EN bit is 0 SHALL be accepted and dropped: err_no_cap and err_pf SHALL pulse in the cycle after the grant, no tag SHALL be allocated, and the FSM SHALL remain in IDLE.
REQ-019 tx_valid SHALL rise in the cycle after the grant (1-cycle latency), and the payload SHALL be registered and held stable until tx_valid && tx_ready.
REQ-020 On tx_valid && tx_ready the FSM SHALL return to IDLE, and a new grant is permitted in that same cycle.
REQ-021 The tag SHALL be the lowest-numbered free tag, and it SHALL be marked allocated at grant.
REQ-022 When all NUM_TAGS tags are allocated, req_ready SHALL be all-zero, including for ATS-disabled PFs.
REQ-023 cpl_valid SHALL free cpl_tag at the next edge; a completion on an unallocated tag SHALL pulse err_bad_cpl and SHALL leave state unchanged.
REQ-024 When allocate and free occur in the same cycle, outstanding SHALL be unchanged, and the freed tag SHALL NOT be reallocated in that cycle.
REQ-025 A completion arriving while full SHALL allow a grant in the following cycle.

Reset
REQ-026 Assertion of rst at any time, including in HOLD, SHALL asynchronously force: FSM = IDLE; req_ready = 0; tx_valid = 0; tx_pf = 0; tx_addr = 0; tx_tag = 0; err_no_cap = 0; err_pf = 0; err_bad_cpl = 0; all tags free; outstanding = 0; round-robin pointer = PF0.
REQ-027 Any in-flight request SHALL be discarded at reset, and no completion tracking SHALL survive it.

Structure
REQ-028 Package pcie_ats_arb_pkg SHALL hold the state enum, the tx payload struct (pf, addr, tag), and the PAGE_SHIFT = 12 constant.
REQ-029 Round-robin arbitration SHALL live in sub-module pcie_ats_rr_arb (request vector and advance strobe in; one-hot grant out).
REQ-030 Lowest-free-tag selection SHALL be a combinational priority encoder within the top module.

Verification
REQ-031 Single request: after reset, PF2 requests addr 0x1234_5000 -> req_ready[2] pulses, next cycle tx_pf=2, tx_addr=0x12345, tx_tag=0, outstanding=1.
REQ-032 Fairness: PF0, PF1 and PF3 request continuously with tx_ready=1 -> grants occur in the order 0,1,3,0,1,3, with no PF starved.
REQ-033 No capability: with ATS_CAP_EN=8'b1111_1110, PF0 requests -> err_no_cap pulses with err_pf=0, tx_valid stays 0, outstanding=0.
REQ-034 Full and backpressure: 16 grants without completions -> req_ready=0; cpl_tag=5 -> next grant uses tag 5; tx_ready held low for 10 cycles -> payload stable throughout.
REQ-035 Bad completion and simultaneity: cpl_tag=7 with nothing outstanding -> err_bad_cpl pulses; a completion coinciding with a grant -> outstanding unchanged.
REQ-036 Reset mid-HOLD: rst asserted while tx_valid=1 -> tx_valid drops asynchronously, outstanding=0, and the first grant after release goes to PF0.

Source files
------------

// File: rtl/pcie_ats_arb_pkg.sv
// Shared types for the ATS translation-request arbiter: FSM states, egress payload, page geometry.
// No logic here; widths are sized for the largest legal configuration.
package pcie_ats_arb_pkg;

    localparam int PAGE_SHIFT = 12;
    localparam int PF_W       = 3;
    localparam int ADDR_W     = 64 - PAGE_SHIFT;
    localparam int TAG_W_MAX  = 5;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [PF_W-1:0]      pf;
        logic [ADDR_W-1:0]    addr;
        logic [TAG_W_MAX-1:0] tag;
    } tx_payload_t;

endpackage

// File: rtl/pcie_ats_rr_arb.sv
// Round-robin arbiter over the PF request vector; one-hot grant.
// Latency: grant is combinational; the priority pointer moves on the advance strobe.
// Backpressure: the pointer only moves when the caller accepts the grant via adv.
module pcie_ats_rr_arb
    import pcie_ats_arb_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         adv,
    output logic [N-1:0] gnt
);

    logic [PF_W-1:0] ptr_q, ptr_d;
    logic [PF_W-1:0] win;
    logic            found;
    int              idx;

    always_comb begin
        gnt   = '0;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_q) + i) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                win      = PF_W'(idx);
                gnt[idx] = 1'b1;
            end
        end
    end

    // Next search starts just after the PF that was served.
    always_comb begin
        ptr_d = ptr_q;
        if (adv && found) begin
            ptr_d = (win == PF_W'(N - 1)) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/pcie_ats_req_arb.sv
// Arbitrates per-PF ATS translation requests onto one egress port and tracks outstanding tags.
// Latency: req_ready in the grant cycle, tx_valid one cycle later; errors pulse one cycle after cause.
// Backpressure: one request in flight; payload held until tx_ready, no grants while all tags are in use.
module pcie_ats_req_arb
    import pcie_ats_arb_pkg::*;
#(
    parameter int                 NUM_PFS    = 8,
    parameter logic [NUM_PFS-1:0] ATS_CAP_EN = '1,
    parameter int                 NUM_TAGS   = 16,
    localparam int                TAG_W      = $clog2(NUM_TAGS),
    localparam int                CNT_W      = TAG_W + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_PFS-1:0]       req_valid,
    input  logic [NUM_PFS-1:0][63:0] req_addr,
    output logic [NUM_PFS-1:0]       req_ready,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [PF_W-1:0]          tx_pf,
    output logic [ADDR_W-1:0]        tx_addr,
    output logic [TAG_W-1:0]         tx_tag,
    input  logic                     cpl_valid,
    input  logic [TAG_W-1:0]         cpl_tag,
    output logic                     err_no_cap,
    output logic [PF_W-1:0]          err_pf,
    output logic                     err_bad_cpl,
    output logic [CNT_W-1:0]         outstanding
);

    arb_state_e          state_q, state_d;
    logic [NUM_TAGS-1:0] alloc_q, alloc_d;
    logic [CNT_W-1:0]    outstanding_q, outstanding_d;
    tx_payload_t         payload_q, payload_d;
    logic                tx_valid_q, tx_valid_d;
    logic                err_no_cap_q, err_no_cap_d;
    logic [PF_W-1:0]     err_pf_q, err_pf_d;
    logic                err_bad_cpl_q, err_bad_cpl_d;

    logic [NUM_PFS-1:0]  rr_gnt;
    logic [PF_W-1:0]     gnt_pf;
    logic [ADDR_W-1:0]   gnt_addr;
    logic [TAG_W-1:0]    free_tag;
    logic                tag_avail;
    logic                tx_fire;
    logic                slot_open;
    logic                grant;
    logic                gnt_cap;
    logic                do_alloc;
    logic                do_free;
    logic                unused_bits;

    pcie_ats_rr_arb #(.N(NUM_PFS)) u_rr (
        .clk (clk),
        .rst (rst),
        .req (req_valid),
        .adv (grant),
        .gnt (rr_gnt)
    );

    // Lowest free tag; a tag freed this cycle is still marked allocated here.
    always_comb begin
        free_tag  = '0;
        tag_avail = 1'b0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!alloc_q[i]) begin
                free_tag  = TAG_W'(i);
                tag_avail = 1'b1;
            end
        end
    end

    always_comb begin
        gnt_pf   = '0;
        gnt_addr = '0;
        for (int i = 0; i < NUM_PFS; i++) begin
            if (rr_gnt[i]) begin
                gnt_pf   = PF_W'(i);
                gnt_addr = req_addr[i][63:PAGE_SHIFT];
            end
        end
    end

    assign tx_fire   = tx_valid_q && tx_ready;
    assign slot_open = (state_q == IDLE) || tx_fire;
    assign grant     = !rst && slot_open && tag_avail && (|req_valid);
    assign gnt_cap   = |(rr_gnt & ATS_CAP_EN);
    assign do_alloc  = grant && gnt_cap;
    assign do_free   = cpl_valid && alloc_q[cpl_tag];

    always_comb begin
        alloc_d = alloc_q;
        if (do_free) begin
            alloc_d[cpl_tag] = 1'b0;
        end
        if (do_alloc) begin
            alloc_d[free_tag] = 1'b1;
        end
        outstanding_d = outstanding_q + CNT_W'(do_alloc) - CNT_W'(do_free);
    end

    always_comb begin
        state_d    = state_q;
        tx_valid_d = tx_valid_q;
        payload_d  = payload_q;
        if (tx_fire) begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
        end
        if (do_alloc) begin
            state_d        = HOLD;
            tx_valid_d     = 1'b1;
            payload_d.pf   = gnt_pf;
            payload_d.addr = gnt_addr;
            payload_d.tag  = TAG_W_MAX'(free_tag);
        end
        err_no_cap_d  = grant && !gnt_cap;
        err_pf_d      = (grant && !gnt_cap) ? gnt_pf : '0;
        err_bad_cpl_d = cpl_valid && !alloc_q[cpl_tag];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            alloc_q       <= '0;
            outstanding_q <= '0;
            payload_q     <= '0;
            tx_valid_q    <= 1'b0;
            err_no_cap_q  <= 1'b0;
            err_pf_q      <= '0;
            err_bad_cpl_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            alloc_q       <= alloc_d;
            outstanding_q <= outstanding_d;
            payload_q     <= payload_d;
            tx_valid_q    <= tx_valid_d;
            err_no_cap_q  <= err_no_cap_d;
            err_pf_q      <= err_pf_d;
            err_bad_cpl_q <= err_bad_cpl_d;
        end
    end

    assign req_ready   = grant ? rr_gnt : '0;
    assign tx_valid    = tx_valid_q;
    assign tx_pf       = payload_q.pf;
    assign tx_addr     = payload_q.addr;
    assign tx_tag      = payload_q.tag[TAG_W-1:0];
    assign err_no_cap  = err_no_cap_q;
    assign err_pf      = err_pf_q;
    assign err_bad_cpl = err_bad_cpl_q;
    assign outstanding = outstanding_q;

    // Page-offset bits and spare tag bits are intentionally ignored.
    assign unused_bits = ^{req_addr, payload_q.tag};

endmodule

// File: tb/tb_pcie_ats_req_arb.sv
// Scoreboard bench for pcie_ats_req_arb: expected egress payloads queued at grant, popped on tx handshake.
module tb_pcie_ats_req_arb;

    localparam logic [7:0] CAP = 8'b1111_1110;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       req_valid;
    logic [7:0][63:0] req_addr;
    logic [7:0]       req_ready;
    logic             tx_valid;
    logic             tx_ready;
    logic [2:0]       tx_pf;
    logic [51:0]      tx_addr;
    logic [3:0]       tx_tag;
    logic             cpl_valid;
    logic [3:0]       cpl_tag;
    logic             err_no_cap;
    logic [2:0]       err_pf;
    logic             err_bad_cpl;
    logic [4:0]       outstanding;

    int          checks = 0;
    int          errors = 0;
    logic [58:0] sb_q[$];
    logic [15:0] m_alloc;
    int          m_cnt;
    int          grants;
    int          n;
    int          exp_order[6] = '{0, 1, 3, 0, 1, 3};
    logic [51:0] pf1_page;

    pcie_ats_req_arb #(
        .NUM_PFS    (8),
        .ATS_CAP_EN (CAP),
        .NUM_TAGS   (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_pf       (tx_pf),
        .tx_addr     (tx_addr),
        .tx_tag      (tx_tag),
        .cpl_valid   (cpl_valid),
        .cpl_tag     (cpl_tag),
        .err_no_cap  (err_no_cap),
        .err_pf      (err_pf),
        .err_bad_cpl (err_bad_cpl),
        .outstanding (outstanding)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] pf_addr(input int p);
        return 64'h0000_00ab_0000_0a5c + (64'(p) << 24);
    endfunction

    function automatic int lowest_free();
        int r = 0;
        for (int i = 15; i >= 0; i--) begin
            if (!m_alloc[i]) r = i;
        end
        return r;
    endfunction

    // Model a grant to PF p: ATS-capable PFs take the lowest free tag and will emit a payload.
    task automatic expect_grant(input int p);
        int t;
        if (CAP[p]) begin
            t = lowest_free();
            m_alloc[t] = 1'b1;
            m_cnt++;
            sb_q.push_back({3'(p), req_addr[p][63:12], 4'(t)});
        end
    endtask

    task automatic model_free(input int t);
        m_alloc[t] = 1'b0;
        m_cnt--;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [58:0] e;
        if (!rst && tx_valid && tx_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("tx_unexpected", 64'(tx_valid), 64'(0));
            end else begin
                e = sb_q.pop_front();
                check_eq("tx_payload", {5'b0, tx_pf, tx_addr, tx_tag}, {5'b0, e});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        req_valid = 8'hff;
        tx_ready  = 1'b0;
        cpl_valid = 1'b0;
        cpl_tag   = '0;
        m_alloc   = '0;
        m_cnt     = 0;
        for (int p = 0; p < 8; p++) req_addr[p] = pf_addr(p);
        pf1_page = pf_addr(1) >> 12;

        // Reset state, with requests pending to show they are not accepted.
        step();
        @(negedge clk);
        check_eq("rst_req_ready", req_ready, 8'h00);
        check_eq("rst_tx_valid", tx_valid, 0);
        check_eq("rst_outstanding", outstanding, 0);
        check_eq("rst_errs", {err_no_cap, err_pf, err_bad_cpl, tx_pf, tx_tag}, 0);
        req_valid = 8'h00;
        step();
        rst = 1'b0;
        step();

        // Single request from PF2.
        req_addr[2] = 64'h0000_0000_1234_5000;
        req_valid   = 8'h04;
        @(negedge clk);
        check_eq("single_req_ready", req_ready, 8'h04);
        expect_grant(2);
        step();
        req_valid = 8'h00;
        @(negedge clk);
        check_eq("single_tx_valid", tx_valid, 1);
        check_eq("single_tx_fields", {tx_pf, tx_addr, tx_tag}, {3'd2, 52'h12345, 4'd0});
        check_eq("single_outstanding", outstanding, 1);
        check_eq("single_req_ready_pulse", req_ready, 8'h00);
        step();
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        @(negedge clk);
        check_eq("single_tx_done", tx_valid, 0);
        step();
        cpl_valid = 1'b1;
        cpl_tag   = 4'd0;
        model_free(0);
        step();
        cpl_valid = 1'b0;
        @(negedge clk);
        check_eq("single_cpl_outstanding", outstanding, m_cnt);
        check_eq("single_cpl_no_err", err_bad_cpl, 0);

        // PF0 has ATS disabled: accepted and dropped.
        step();
        req_valid = 8'h01;
        @(negedge clk);
        check_eq("nocap_req_ready", req_ready, 8'h01);
        expect_grant(0);
        step();
        req_valid = 8'h00;
        @(negedge clk);
        check_eq("nocap_err", {err_no_cap, err_pf}, {1'b1, 3'd0});
        check_eq("nocap_tx_valid", tx_valid, 0);
        check_eq("nocap_outstanding", outstanding, 0);
        step();
        @(negedge clk);
        check_eq("nocap_err_pulse", err_no_cap, 0);

        // Completion on a tag that is not outstanding.
        step();
        cpl_valid = 1'b1;
        cpl_tag   = 4'd7;
        step();
        cpl_valid = 1'b0;
        @(negedge clk);
        check_eq("badcpl_err", err_bad_cpl, 1);
        check_eq("badcpl_outstanding", outstanding, 0);
        step();
        @(negedge clk);
        check_eq("badcpl_pulse", err_bad_cpl, 0);

        // Grant and completion in the same cycle.
        step();
        tx_ready  = 1'b1;
        req_valid = 8'h02;
        @(negedge clk);
        check_eq("simul_first_grant", req_ready, 8'h02);
        expect_grant(1);
        step();
        req_valid = 8'h00;
        @(negedge clk);
        check_eq("simul_first_outstanding", outstanding, 1);
        step();
        req_valid = 8'h02;
        cpl_valid = 1'b1;
        cpl_tag   = 4'd0;
        @(negedge clk);
        check_eq("simul_grant", req_ready, 8'h02);
        expect_grant(1);
        model_free(0);
        step();
        req_valid = 8'h00;
        cpl_valid = 1'b0;
        @(negedge clk);
        check_eq("simul_outstanding", outstanding, 1);
        check_eq("simul_tag_not_reused", tx_tag, 1);
        step();
        cpl_valid = 1'b1;
        cpl_tag   = 4'd1;
        model_free(1);
        step();
        cpl_valid = 1'b0;
        tx_ready  = 1'b0;
        @(negedge clk);
        check_eq("simul_drained", outstanding, m_cnt);

        // Fill every tag from PF1.
        step();
        tx_ready  = 1'b1;
        req_valid = 8'h02;
        grants    = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (req_ready[1]) begin
                grants++;
                expect_grant(1);
            end
            step();
        end
        req_valid = 8'h01;
        @(negedge clk);
        check_eq("full_grants", grants, 16);
        check_eq("full_outstanding", outstanding, 16);
        check_eq("full_nocap_blocked", req_ready, 8'h00);
        step();
        req_valid = 8'h02;
        tx_ready  = 1'b0;
        cpl_valid = 1'b1;
        cpl_tag   = 4'd5;
        model_free(5);
        @(negedge clk);
        check_eq("full_cpl_cycle_no_grant", req_ready, 8'h00);
        step();
        cpl_valid = 1'b0;
        @(negedge clk);
        check_eq("after_full_grant", req_ready, 8'h02);
        expect_grant(1);
        step();
        req_valid = 8'h00;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_eq("bp_stable", {tx_valid, tx_pf, tx_addr, tx_tag}, {1'b1, 3'd1, pf1_page, 4'd5});
            step();
        end

        // Asynchronous reset while holding a payload.
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_hold_tx_valid", tx_valid, 0);
        check_eq("rst_hold_outstanding", outstanding, 0);
        sb_q.delete();
        m_alloc   = '0;
        m_cnt     = 0;
        req_valid = 8'h0b;
        tx_ready  = 1'b1;
        @(negedge clk);
        check_eq("rst_hold_req_ready", req_ready, 8'h00);
        step();
        rst = 1'b0;

        // Fairness across PF0, PF1, PF3 starting from PF0.
        n = 0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            @(negedge clk);
            if (req_ready != 8'h00) begin
                check_eq("rr_order", req_ready, 64'(1) << exp_order[n]);
                expect_grant(exp_order[n]);
                n++;
            end
            step();
        end
        req_valid = 8'h00;
        check_eq("rr_grant_count", n, 6);
        step();
        step();
        @(negedge clk);
        check_eq("rr_outstanding", outstanding, m_cnt);
        check_eq("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
